// File: rtl/turn_input_conditioner.sv
// Debounces the two turn buttons and turns their presses into single-cycle turn pulses,
// allowing at most one turn per refresh frame with a one-deep deferred-turn queue.
module turn_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       btn_r_raw,
    input  logic       btn_l_raw,
    input  logic       refr_tick,
    output logic       turn_r,
    output logic       turn_l,
    output logic       btn_r_level,
    output logic       btn_l_level,
    output logic       turn_pending,
    output logic [7:0] drop_cnt
);

    localparam logic             RELEASED_RAW = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 is the right button, bit 1 the left button.
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_stable_d;
    logic [1:0] w_pressed;
    logic [1:0] w_stable;
    logic [1:0] w_ev;

    logic       r_gate_open;
    logic       r_pend_valid;
    logic       r_pend_dir;
    logic       r_turn_r;
    logic       r_turn_l;
    logic [7:0] r_drop_cnt;

    logic       w_gate_nxt;
    logic       w_pv_nxt;
    logic       w_pd_nxt;
    logic       w_tr_nxt;
    logic       w_tl_nxt;
    logic [1:0] w_drop_inc;
    logic [8:0] w_drop_sum;
    logic [7:0] w_drop_nxt;

    // Two-flop synchronizers, reset to the released raw level so no spurious press appears.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= {2{RELEASED_RAW}};
            r_sync2 <= {2{RELEASED_RAW}};
        end else begin
            r_sync1 <= {btn_l_raw, btn_r_raw};
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = r_sync2 ^ {2{RELEASED_RAW}};

    for (genvar g = 0; g < 2; g++) begin : g_db
        logic [CNT_W-1:0] r_cnt;
        logic             r_stab;

        // Stable state only follows the synchronized input after DEBOUNCE_CYCLES of disagreement.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_cnt  <= {CNT_W{1'b0}};
                r_stab <= 1'b0;
            end else if (w_pressed[g] == r_stab) begin
                r_cnt  <= {CNT_W{1'b0}};
            end else if (r_cnt == CNT_LAST) begin
                r_cnt  <= {CNT_W{1'b0}};
                r_stab <= ~r_stab;
            end else begin
                r_cnt  <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end

        assign w_stable[g] = r_stab;
    end

    assign w_ev = w_stable & ~r_stable_d;

    // Frame gate, deferred turn and drop accounting; the tick is applied before the event.
    always_comb begin
        w_gate_nxt = r_gate_open;
        w_pv_nxt   = r_pend_valid;
        w_pd_nxt   = r_pend_dir;
        w_tr_nxt   = 1'b0;
        w_tl_nxt   = 1'b0;
        w_drop_inc = 2'd0;
        if (refr_tick) begin
            if (r_pend_valid) begin
                w_tr_nxt = ~r_pend_dir;
                w_tl_nxt = r_pend_dir;
                w_pv_nxt = 1'b0;
            end else begin
                w_gate_nxt = 1'b1;
            end
        end else begin
            w_gate_nxt = r_gate_open;
        end
        if (w_ev == 2'b11) begin
            w_drop_inc = 2'd2;
        end else if (w_ev != 2'b00) begin
            if (w_gate_nxt) begin
                w_tr_nxt   = w_ev[0];
                w_tl_nxt   = w_ev[1];
                w_gate_nxt = 1'b0;
            end else if (!w_pv_nxt) begin
                w_pv_nxt = 1'b1;
                w_pd_nxt = w_ev[1];
            end else begin
                w_drop_inc = 2'd1;
            end
        end else begin
            w_drop_inc = 2'd0;
        end
    end

    assign w_drop_sum = {1'b0, r_drop_cnt} + {7'd0, w_drop_inc};
    assign w_drop_nxt = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];

    // Arbitration state and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stable_d   <= 2'b00;
            r_gate_open  <= 1'b1;
            r_pend_valid <= 1'b0;
            r_pend_dir   <= 1'b0;
            r_turn_r     <= 1'b0;
            r_turn_l     <= 1'b0;
            r_drop_cnt   <= 8'd0;
        end else begin
            r_stable_d   <= w_stable;
            r_gate_open  <= w_gate_nxt;
            r_pend_valid <= w_pv_nxt;
            r_pend_dir   <= w_pd_nxt;
            r_turn_r     <= w_tr_nxt;
            r_turn_l     <= w_tl_nxt;
            r_drop_cnt   <= w_drop_nxt;
        end
    end

    assign turn_r       = r_turn_r;
    assign turn_l       = r_turn_l;
    assign btn_r_level  = w_stable[0];
    assign btn_l_level  = w_stable[1];
    assign turn_pending = r_pend_valid;
    assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_turn_input_conditioner.sv
// Directed bench for turn_input_conditioner with DEBOUNCE_CYCLES=4, active-low buttons.
module tb_turn_input_conditioner;

    logic       clk = 1'b0;
    logic       rstn;
    logic       btn_r_raw;
    logic       btn_l_raw;
    logic       refr_tick;
    logic       turn_r;
    logic       turn_l;
    logic       btn_r_level;
    logic       btn_l_level;
    logic       turn_pending;
    logic [7:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    turn_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .btn_r_raw   (btn_r_raw),
        .btn_l_raw   (btn_l_raw),
        .refr_tick   (refr_tick),
        .turn_r      (turn_r),
        .turn_l      (turn_l),
        .btn_r_level (btn_r_level),
        .btn_l_level (btn_l_level),
        .turn_pending(turn_pending),
        .drop_cnt    (drop_cnt)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic release_all();
        btn_r_raw = 1'b1;
        btn_l_raw = 1'b1;
        step(8);
    endtask

    task automatic test_reset();
        rstn = 1'b0; btn_r_raw = 1'b1; btn_l_raw = 1'b1; refr_tick = 1'b0;
        step(3);
        total++;
        if ({turn_r, turn_l, btn_r_level, btn_l_level, turn_pending, drop_cnt} !== 13'd0) begin
            bad++;
            $display("FAIL reset outs got=%b want=0", {turn_r, turn_l, btn_r_level, btn_l_level, turn_pending, drop_cnt});
        end
        rstn = 1'b1;
        step(2);
    endtask

    task automatic test_single_press();
        btn_r_raw = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            total++;
            if ({btn_r_level, turn_r, turn_l} !== {(i >= 6), (i == 7), 1'b0}) begin
                bad++;
                $display("FAIL single_press edge+%0d got lvl/tr/tl=%b want=%b", i,
                         {btn_r_level, turn_r, turn_l}, {(i >= 6), (i == 7), 1'b0});
            end
        end
        release_all();
        total++;
        if ({btn_r_level, turn_r} !== 2'b00) begin
            bad++; $display("FAIL release got lvl/tr=%b want=00", {btn_r_level, turn_r});
        end
    endtask

    task automatic test_glitch();
        btn_l_raw = 1'b0;
        step(3);
        btn_l_raw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            total++;
            if ({btn_l_level, turn_l, drop_cnt} !== 10'd0) begin
                bad++; $display("FAIL glitch got lvl/tl/drop=%b want=0", {btn_l_level, turn_l, drop_cnt});
            end
        end
    endtask

    task automatic test_defer();
        refr_tick = 1'b1; step(1); refr_tick = 1'b0;
        btn_r_raw = 1'b0; step(7);
        total++;
        if ({turn_r, turn_pending} !== 2'b10) begin
            bad++; $display("FAIL defer_r_now got tr/pend=%b want=10", {turn_r, turn_pending});
        end
        step(1);
        total++;
        if (turn_r !== 1'b0) begin
            bad++; $display("FAIL defer_r_width got=%b want=0", turn_r);
        end
        release_all();
        btn_l_raw = 1'b0; step(7);
        total++;
        if ({turn_l, turn_pending} !== 2'b01) begin
            bad++; $display("FAIL defer_l_queued got tl/pend=%b want=01", {turn_l, turn_pending});
        end
        release_all();
        refr_tick = 1'b1; step(1); refr_tick = 1'b0;
        total++;
        if ({turn_r, turn_l, turn_pending} !== 3'b010) begin
            bad++; $display("FAIL defer_l_emit got tr/tl/pend=%b want=010", {turn_r, turn_l, turn_pending});
        end
        step(1);
        total++;
        if (turn_l !== 1'b0) begin
            bad++; $display("FAIL defer_l_width got=%b want=0", turn_l);
        end
    endtask

    task automatic test_drop_when_pending();
        btn_r_raw = 1'b0; step(7);
        total++;
        if ({turn_r, turn_pending} !== 2'b01) begin
            bad++; $display("FAIL pend_r got tr/pend=%b want=01", {turn_r, turn_pending});
        end
        release_all();
        for (int k = 1; k <= 2; k++) begin
            btn_l_raw = 1'b0; step(7);
            total++;
            if ({turn_l, turn_pending, drop_cnt} !== {1'b0, 1'b1, 8'(k)}) begin
                bad++; $display("FAIL drop_%0d got tl/pend/drop=%b want=%b", k,
                                {turn_l, turn_pending, drop_cnt}, {1'b0, 1'b1, 8'(k)});
            end
            release_all();
        end
        refr_tick = 1'b1; step(1); refr_tick = 1'b0;
        total++;
        if ({turn_r, turn_l, turn_pending} !== 3'b100) begin
            bad++; $display("FAIL pend_r_emit got tr/tl/pend=%b want=100", {turn_r, turn_l, turn_pending});
        end
        step(1);
        total++;
        if ({turn_r, turn_l} !== 2'b00) begin
            bad++; $display("FAIL pend_r_width got=%b want=00", {turn_r, turn_l});
        end
    endtask

    task automatic test_back_to_back();
        refr_tick = 1'b1; step(1); refr_tick = 1'b0;
        btn_r_raw = 1'b0; btn_l_raw = 1'b0; step(7);
        total++;
        if ({turn_r, turn_l, turn_pending, drop_cnt} !== {3'b000, 8'd4}) begin
            bad++; $display("FAIL collide got tr/tl/pend/drop=%b want=%b",
                            {turn_r, turn_l, turn_pending, drop_cnt}, {3'b000, 8'd4});
        end
        release_all();
        btn_r_raw = 1'b0; step(7);
        total++;
        if ({turn_r, turn_l, turn_pending} !== 3'b100) begin
            bad++; $display("FAIL collide_gate_open got tr/tl/pend=%b want=100", {turn_r, turn_l, turn_pending});
        end
        release_all();
    endtask

    task automatic test_async_reset();
        btn_r_raw = 1'b0; step(7);
        total++;
        if (turn_pending !== 1'b1) begin
            bad++; $display("FAIL arst_setup got pend=%b want=1", turn_pending);
        end
        release_all();
        #2 rstn = 1'b0;
        #1;
        total++;
        if ({turn_r, turn_l, btn_r_level, btn_l_level, turn_pending, drop_cnt} !== 13'd0) begin
            bad++;
            $display("FAIL arst_outs got=%b want=0", {turn_r, turn_l, btn_r_level, btn_l_level, turn_pending, drop_cnt});
        end
        #3 rstn = 1'b1;
        step(1);
        refr_tick = 1'b1; step(1); refr_tick = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({turn_r, turn_l, turn_pending, drop_cnt} !== 11'd0) begin
                bad++; $display("FAIL arst_no_turn got tr/tl/pend/drop=%b want=0", {turn_r, turn_l, turn_pending, drop_cnt});
            end
            step(1);
        end
    endtask

    task automatic test_drop_saturation();
        for (int k = 1; k <= 129; k++) begin
            btn_r_raw = 1'b0; btn_l_raw = 1'b0; step(7);
            if (k >= 127) begin
                total++;
                if (drop_cnt !== ((k == 127) ? 8'd254 : 8'd255)) begin
                    bad++; $display("FAIL drop_sat_%0d got=%0d want=%0d", k, drop_cnt, (k == 127) ? 254 : 255);
                end
            end
            release_all();
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_defer();
        test_drop_when_pending();
        test_back_to_back();
        test_async_reset();
        test_drop_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
